chara_motion: RTL and testbench

Per-frame motion and animation controller for the main character sprite. It sits directly upstream of the moving-sprite renderer. Once per video frame it samples the player controls and updates the horizontal position, vertical position and jump/fall physics. It then presents the sprite's top-left screen coordinate, the animation frame index and the facing direction to the renderer, which only draws.

---
 rtl/chara_pkg.sv | 22 ++
 rtl/sprite_anim_ctr.sv | 39 +++
 rtl/chara_motion.sv | 151 +++++++++++++++
 tb/tb_chara_motion.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/chara_pkg.sv
// Shared types and default physics constants for the character motion controller.
package chara_pkg;

    // Motion state of the character
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        JUMP = 2'd2,
        FALL = 2'd3
    } chara_state_t;

    // Default physics constants (px/frame)
    localparam int DEF_JUMP_V   = 16;
    localparam int DEF_GRAVITY  = 1;
    localparam int DEF_MAX_FALL = 16;

    // True when the character stands on the ground
    function automatic logic is_grounded(input chara_state_t s);
        return (s == IDLE) || (s == WALK);
    endfunction

endpackage

// File: rtl/sprite_anim_ctr.sv
// Walk-cycle animation counter: divides frame advances by ANIM_DIV and steps
// the sprite frame index, wrapping after SPR_FRAMES-1.
module sprite_anim_ctr #(
    parameter  int ANIM_DIV   = 8,
    parameter  int SPR_FRAMES = 3,
    localparam int CNTW       = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1,
    localparam int IDXW       = (SPR_FRAMES > 1) ? $clog2(SPR_FRAMES) : 1
) (
    input  logic            i_clk_pix,
    input  logic            i_rst,
    input  logic            i_adv,
    input  logic            i_clr,
    output logic [IDXW-1:0] o_idx
);

    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(ANIM_DIV - 1);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(SPR_FRAMES - 1);

    logic [CNTW-1:0] r_cnt;
    logic [IDXW-1:0] r_idx;

    // Clear restarts the cycle; advance steps the divider and the frame index
    always_ff @(posedge i_clk_pix) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (i_adv) begin
            if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDXW'(1);
            end else begin
                r_cnt <= r_cnt + CNTW'(1);
            end
        end
    end

    assign o_idx = r_idx;

endmodule

// File: rtl/chara_motion.sv
// Per-frame character motion controller: horizontal walk with clamping,
// jump/fall physics and animation frame selection for the sprite renderer.
module chara_motion
    import chara_pkg::*;
#(
    parameter  int CORDW      = 16,
    parameter  int H_RES      = 800,
    parameter  int V_RES      = 600,
    parameter  int SPR_W      = 76,
    parameter  int SPR_H      = 108,
    parameter  int SPR_FRAMES = 3,
    parameter  int ANIM_DIV   = 8,
    parameter  int X_START    = (H_RES - SPR_W) / 2,
    parameter  int GROUND_Y   = V_RES - SPR_H,
    parameter  int JUMP_V     = DEF_JUMP_V,
    parameter  int GRAVITY    = DEF_GRAVITY,
    parameter  int MAX_FALL   = DEF_MAX_FALL,
    localparam int IDXW       = (SPR_FRAMES > 1) ? $clog2(SPR_FRAMES) : 1
) (
    input  logic                    i_clk_pix,
    input  logic                    i_rst,
    input  logic                    i_frame,
    input  logic                    i_left,
    input  logic                    i_right,
    input  logic                    i_jump,
    input  logic [CORDW-1:0]        i_speed,
    output logic signed [CORDW-1:0] o_x,
    output logic signed [CORDW-1:0] o_y,
    output logic [IDXW-1:0]         o_frame_idx,
    output logic                    o_facing_left,
    output logic                    o_airborne,
    output logic                    o_update
);

    // Two guard bits so x +/- speed and y + vy never wrap before clamping
    localparam int XW = CORDW + 2;

    localparam logic signed [XW-1:0]    X_MAX      = XW'(H_RES - SPR_W);
    localparam logic signed [XW-1:0]    Y_GND_W    = XW'(GROUND_Y);
    localparam logic signed [CORDW-1:0] X_RST      = CORDW'(X_START);
    localparam logic signed [CORDW-1:0] Y_GND      = CORDW'(GROUND_Y);
    localparam logic signed [CORDW-1:0] VY_TAKEOFF = CORDW'(-JUMP_V);
    localparam logic signed [CORDW-1:0] VY_GRAV    = CORDW'(GRAVITY);
    localparam logic signed [CORDW-1:0] VY_MAX     = CORDW'(MAX_FALL);
    localparam logic [IDXW-1:0]         IDX_AIR    = IDXW'(SPR_FRAMES - 1);

    chara_state_t            r_state, w_state_next, w_ground_state;
    logic signed [CORDW-1:0] r_x, r_y, r_vy;
    logic signed [CORDW-1:0] w_x_next, w_y_next, w_vy_next;
    logic signed [CORDW-1:0] w_vy_cur, w_vy_inc;
    logic signed [XW-1:0]    w_dx, w_x_sum, w_y_sum;
    logic                    r_jump_prev, r_facing, r_update;
    logic                    w_facing_next, w_move_l, w_move_r;
    logic                    w_grounded, w_jump_go, w_airborne;
    logic [IDXW-1:0]         w_anim_idx;

    // Horizontal motion, clamping and facing direction
    always_comb begin
        w_move_l = i_left & ~i_right;
        w_move_r = i_right & ~i_left;
        w_dx     = signed'({2'b00, i_speed});
        w_x_sum  = {{2{r_x[CORDW-1]}}, r_x};
        if (w_move_l) begin
            w_x_sum = w_x_sum - w_dx;
        end else if (w_move_r) begin
            w_x_sum = w_x_sum + w_dx;
        end
        if (w_x_sum < 0) begin
            w_x_next = '0;
        end else if (w_x_sum > X_MAX) begin
            w_x_next = CORDW'(X_MAX);
        end else begin
            w_x_next = w_x_sum[CORDW-1:0];
        end
        w_facing_next  = w_move_l ? 1'b1 : (w_move_r ? 1'b0 : r_facing);
        w_ground_state = (w_move_l | w_move_r) ? WALK : IDLE;
    end

    // Vertical physics and next-state selection
    always_comb begin
        w_grounded   = is_grounded(r_state);
        w_jump_go    = i_jump & ~r_jump_prev & w_grounded;
        w_vy_cur     = w_jump_go ? VY_TAKEOFF : r_vy;
        w_y_sum      = {{2{r_y[CORDW-1]}}, r_y} + {{2{w_vy_cur[CORDW-1]}}, w_vy_cur};
        w_vy_inc     = w_vy_cur + VY_GRAV;
        w_state_next = r_state;
        w_y_next     = r_y;
        w_vy_next    = r_vy;
        if (w_grounded && !w_jump_go) begin
            w_state_next = w_ground_state;
        end else if (w_y_sum < 0) begin
            // Hit the top of the screen: stop rising and start falling
            w_y_next     = '0;
            w_vy_next    = '0;
            w_state_next = FALL;
        end else if (w_y_sum >= Y_GND_W) begin
            // Landed: rest on the ground and resume walking/idling
            w_y_next     = Y_GND;
            w_vy_next    = '0;
            w_state_next = w_ground_state;
        end else begin
            w_y_next     = w_y_sum[CORDW-1:0];
            w_vy_next    = (w_vy_inc > VY_MAX) ? VY_MAX : w_vy_inc;
            w_state_next = (w_vy_next < 0) ? JUMP : FALL;
        end
    end

    // Commit the new motion state once per video frame
    always_ff @(posedge i_clk_pix) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_x         <= X_RST;
            r_y         <= Y_GND;
            r_vy        <= '0;
            r_jump_prev <= 1'b0;
            r_facing    <= 1'b0;
            r_update    <= 1'b0;
        end else begin
            r_update <= i_frame;
            if (i_frame) begin
                r_state     <= w_state_next;
                r_x         <= w_x_next;
                r_y         <= w_y_next;
                r_vy        <= w_vy_next;
                r_jump_prev <= i_jump;
                r_facing    <= w_facing_next;
            end
        end
    end

    // Walk cycle runs only while walking; standing still resets it
    sprite_anim_ctr #(
        .ANIM_DIV   (ANIM_DIV),
        .SPR_FRAMES (SPR_FRAMES)
    ) u_anim (
        .i_clk_pix (i_clk_pix),
        .i_rst     (i_rst),
        .i_adv     (i_frame && (w_state_next == WALK)),
        .i_clr     (i_frame && (w_state_next == IDLE)),
        .o_idx     (w_anim_idx)
    );

    assign w_airborne    = ~is_grounded(r_state);
    assign o_x           = r_x;
    assign o_y           = r_y;
    assign o_frame_idx   = w_airborne ? IDX_AIR : w_anim_idx;
    assign o_facing_left = r_facing;
    assign o_airborne    = w_airborne;
    assign o_update      = r_update;

endmodule

// File: tb/tb_chara_motion.sv
// Scoreboard bench for chara_motion: stimulus pushes reference-model results,
// a negedge monitor pops them on every o_update and checks holds in between.
module tb_chara_motion;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              i_rst   = 1'b1;
    logic              i_frame = 1'b0;
    logic              i_left  = 1'b0;
    logic              i_right = 1'b0;
    logic              i_jump  = 1'b0;
    logic [15:0]       i_speed = 16'd0;
    logic signed [15:0] o_x, o_y;
    logic [1:0]        o_frame_idx;
    logic              o_facing_left, o_airborne, o_update;

    chara_motion dut (
        .i_clk_pix     (clk),
        .i_rst         (i_rst),
        .i_frame       (i_frame),
        .i_left        (i_left),
        .i_right       (i_right),
        .i_jump        (i_jump),
        .i_speed       (i_speed),
        .o_x           (o_x),
        .o_y           (o_y),
        .o_frame_idx   (o_frame_idx),
        .o_facing_left (o_facing_left),
        .o_airborne    (o_airborne),
        .o_update      (o_update)
    );

    typedef struct {
        int x;
        int y;
        int idx;
        bit face;
        bit air;
    } exp_t;

    exp_t exp_q[$];
    exp_t last, e;
    exp_t rst_exp = '{362, 492, 0, 1'b0, 1'b0};
    bit   have_last = 1'b0;
    bit   done = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    // Reference model: plain arithmetic on position, velocity and walk counter
    int m_x, m_y, m_vy, m_cnt, m_idx;
    bit m_air, m_face, m_jprev;

    task automatic model_reset();
        m_x = 362; m_y = 492; m_vy = 0; m_cnt = 0; m_idx = 0;
        m_air = 1'b0; m_face = 1'b0; m_jprev = 1'b0;
    endtask

    task automatic model_step(input bit l, input bit r, input bit j, input int spd);
        int   dir;
        exp_t ex;
        dir = (l && !r) ? -1 : ((r && !l) ? 1 : 0);
        m_x = m_x + dir * spd;
        if (m_x < 0) m_x = 0;
        if (m_x > 724) m_x = 724;
        if (dir < 0) m_face = 1'b1;
        else if (dir > 0) m_face = 1'b0;
        if (!m_air && j && !m_jprev) begin
            m_air = 1'b1;
            m_vy  = -16;
        end
        m_jprev = j;
        if (m_air) begin
            m_y  = m_y + m_vy;
            m_vy = (m_vy + 1 > 16) ? 16 : m_vy + 1;
            if (m_y < 0) begin
                m_y = 0; m_vy = 0;
            end else if (m_y >= 492) begin
                m_y = 492; m_vy = 0; m_air = 1'b0;
            end
        end
        if (m_air) begin
            ex.idx = 2;
        end else if (dir == 0) begin
            m_cnt = 0; m_idx = 0; ex.idx = 0;
        end else begin
            if (m_cnt == 7) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % 3;
            end else begin
                m_cnt = m_cnt + 1;
            end
            ex.idx = m_idx;
        end
        ex.x = m_x; ex.y = m_y; ex.face = m_face; ex.air = m_air;
        exp_q.push_back(ex);
    endtask

    // One frame pulse followed by gap idle cycles (gap 0 gives back-to-back pulses)
    task automatic frame(input bit l, input bit r, input bit j, input int spd, input int gap);
        i_left = l; i_right = r; i_jump = j; i_speed = 16'(spd); i_frame = 1'b1;
        model_step(l, r, j, spd);
        @(posedge clk); #1;
        i_frame = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic reset_pulse(input bit with_frame);
        i_rst = 1'b1; i_frame = with_frame;
        model_reset();
        @(posedge clk); #1;
        i_rst = 1'b0; i_frame = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check(input string name, input exp_t ex);
        total++;
        if (int'(o_x) != ex.x || int'(o_y) != ex.y || int'(o_frame_idx) != ex.idx ||
            o_facing_left !== ex.face || o_airborne !== ex.air) begin
            bad++;
            $display("FAIL %s @%0t: got x=%0d y=%0d idx=%0d face=%0b air=%0b, want x=%0d y=%0d idx=%0d face=%0b air=%0b",
                     name, $time, o_x, o_y, o_frame_idx, o_facing_left, o_airborne,
                     ex.x, ex.y, ex.idx, ex.face, ex.air);
        end
    endtask

    // Monitor: pop on every update, otherwise outputs must hold their last value
    always @(negedge clk) begin
        cyc++;
        if (o_update === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_update @%0t: got o_update=1, want 0", $time);
            end else begin
                e = exp_q.pop_front();
                check("update", e);
                last = e;
                have_last = 1'b1;
            end
        end else if (have_last) begin
            check("hold", last);
        end
        if (i_rst) begin
            last = rst_exp;
            have_last = 1'b1;
        end
        if (done || cyc > 60000) begin
            total++;
            if (cyc > 60000) begin
                bad++;
                $display("FAIL timeout: got cycles=%0d, want <= 60000", cyc);
            end else if (exp_q.size() != 0) begin
                bad++;
                $display("FAIL missing_updates: got pending=%0d, want 0", exp_q.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        i_rst = 1'b0;
        @(posedge clk); #1;

        // Idle frames
        repeat (3) frame(0, 0, 0, 0, 2);
        // Walk right, animation steps at frame 8
        repeat (10) frame(0, 1, 0, 4, 1);
        // Fast walk left into the clamp, back-to-back frames
        reset_pulse(1'b0);
        repeat (5) frame(1, 0, 0, 100, 0);
        // Both directions held: no move
        repeat (3) frame(1, 1, 0, 50, 1);
        // Single jump pulse then release; lands at frame 33
        frame(0, 0, 1, 0, 0);
        repeat (40) frame(0, 0, 0, 0, 0);
        // Jump held for 40 frames while walking: only one jump
        repeat (40) frame(0, 1, 1, 3, 0);
        repeat (2) frame(0, 1, 0, 3, 1);
        // Reset arriving with the fifth frame of a jump
        frame(0, 0, 1, 0, 0);
        repeat (3) frame(0, 0, 0, 0, 0);
        reset_pulse(1'b1);
        repeat (2) frame(0, 0, 0, 0, 1);

        // Randomized controls, speeds, gaps and occasional resets
        for (int n = 0; n < 400; n++) begin
            bit l, r, j;
            int spd;
            l   = bit'($urandom_range(0, 1));
            r   = bit'($urandom_range(0, 1));
            j   = ($urandom_range(0, 3) == 0);
            spd = ($urandom_range(0, 19) == 0) ? 65535 : int'($urandom_range(0, 40));
            frame(l, r, j, spd, int'($urandom_range(0, 2)));
            if ($urandom_range(0, 79) == 0) reset_pulse(bit'($urandom_range(0, 1)));
        end

        repeat (4) @(posedge clk);
        #1;
        done = 1'b1;
    end

endmodule
